// File: rtl/stream_arbiter.sv
// Two-to-one round-robin valid/ready merge with burst lock; output is registered and tagged with its source.
// Latency 1 cycle into an empty buffer; readies drop when the 2-entry (or 1-entry) buffer has no room.
module stream_arbiter #(
    parameter int    WIDTH = 32,
    parameter int    BEATS = 1,
    parameter string BURST = "yes"
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AM0,
    output logic             oReady_AM0,
    input  logic [WIDTH-1:0] iData_AM0,
    input  logic             iValid_AM1,
    output logic             oReady_AM1,
    input  logic [WIDTH-1:0] iData_AM1,
    output logic             oValid_BM,
    input  logic             iReady_BM,
    output logic [WIDTH-1:0] oData_BM,
    output logic             oSelect_BM
);
    localparam bit DEEP = (BURST == "yes");
    localparam int CW   = $clog2(BEATS + 1);

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] dat;
    } entry_t;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    entry_t        mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          space;
    logic          win1;
    logic          acc0;
    logic          acc1;
    logic          push;
    logic          pop;

    // Room is judged from registered occupancy only, so readies never combine with iReady_BM.
    assign space = DEEP ? (count < 2'd2) : (count == 2'd0);

    always_comb begin
        oReady_AM0 = 1'b0;
        oReady_AM1 = 1'b0;
        win1       = iValid_AM1 && (!iValid_AM0 || !last);
        case (state)
            IDLE: begin
                oReady_AM0 = iValid_AM0 && !win1 && space;
                oReady_AM1 = win1 && space;
            end
            GRANT0:  oReady_AM0 = space;
            GRANT1:  oReady_AM1 = space;
            default: ;
        endcase
        if (iRST) begin
            oReady_AM0 = 1'b0;
            oReady_AM1 = 1'b0;
        end
    end

    assign acc0 = iValid_AM0 && oReady_AM0;
    assign acc1 = iValid_AM1 && oReady_AM1;
    assign push = acc0 || acc1;
    assign pop  = oValid_BM && iReady_BM;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else if (push) begin
            case (state)
                IDLE: begin
                    last <= acc1;
                    if (BEATS > 1) begin
                        state <= acc1 ? GRANT1 : GRANT0;
                        cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (cnt == CW'(BEATS - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {acc1, acc1 ? iData_AM1 : iData_AM0};
                if (DEEP) wr_ptr <= ~wr_ptr;
            end
            if (pop && DEEP) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign oValid_BM  = (count != 2'd0);
    assign oData_BM   = mem[rd_ptr].dat;
    assign oSelect_BM = mem[rd_ptr].sel;
endmodule

// File: tb/tb_stream_arbiter.sv
// Drives three arbiter configurations (1-beat/2-deep, 4-beat/2-deep, 1-beat/1-deep) from shared inputs
// and compares each against a queue-based model of the arbitration rules.
module tb_stream_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, ordy;
    logic [31:0] d0, d1;
    logic        r0 [3];
    logic        r1 [3];
    logic        ov [3];
    logic [31:0] od [3];
    logic        os [3];

    int nchk  = 0;
    int nfail = 0;

    // Model state per instance
    int          beats [3] = '{1, 4, 1};
    int          cap   [3] = '{2, 2, 1};
    int          last  [3];
    int          owner [3];
    int          left  [3];
    int          mcnt  [3];
    logic [32:0] mq    [3][2];
    bit          acc0  [3];

    always #5 clk = ~clk;

    stream_arbiter #(.WIDTH(32), .BEATS(1), .BURST("yes")) u_b1 (
        .iCLK(clk), .iRST(rst),
        .iValid_AM0(v0), .oReady_AM0(r0[0]), .iData_AM0(d0),
        .iValid_AM1(v1), .oReady_AM1(r1[0]), .iData_AM1(d1),
        .oValid_BM(ov[0]), .iReady_BM(ordy), .oData_BM(od[0]), .oSelect_BM(os[0]));

    stream_arbiter #(.WIDTH(32), .BEATS(4), .BURST("yes")) u_b4 (
        .iCLK(clk), .iRST(rst),
        .iValid_AM0(v0), .oReady_AM0(r0[1]), .iData_AM0(d0),
        .iValid_AM1(v1), .oReady_AM1(r1[1]), .iData_AM1(d1),
        .oValid_BM(ov[1]), .iReady_BM(ordy), .oData_BM(od[1]), .oSelect_BM(os[1]));

    stream_arbiter #(.WIDTH(32), .BEATS(1), .BURST("no")) u_nb (
        .iCLK(clk), .iRST(rst),
        .iValid_AM0(v0), .oReady_AM0(r0[2]), .iData_AM0(d0),
        .iValid_AM1(v1), .oReady_AM1(r1[2]), .iData_AM1(d1),
        .oValid_BM(ov[2]), .iReady_BM(ordy), .oData_BM(od[2]), .oSelect_BM(os[2]));

    task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            last[k]  = 1;
            owner[k] = -1;
            left[k]  = 0;
            mcnt[k]  = 0;
            acc0[k]  = 1'b0;
        end
    endtask

    // Async reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", k, 64'(ov[k]), 64'd0);
            check("rst_data", k, 64'(od[k]), 64'd0);
            check("rst_sel", k, 64'(os[k]), 64'd0);
            check("rst_rdy0", k, 64'(r0[k]), 64'd0);
            check("rst_rdy1", k, 64'(r1[k]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: check outputs against the model, then advance the model by the rules.
    task automatic step();
        int win;
        bit sp, er0, er1, pop, a0, a1;
        #1;
        for (int k = 0; k < 3; k++) begin
            sp  = (mcnt[k] < cap[k]);
            er0 = 1'b0;
            er1 = 1'b0;
            if (owner[k] < 0) begin
                if (v0 && v1)  win = (last[k] == 0) ? 1 : 0;
                else if (v1)   win = 1;
                else if (v0)   win = 0;
                else           win = -1;
                er0 = (win == 0) && sp;
                er1 = (win == 1) && sp;
            end else begin
                er0 = (owner[k] == 0) && sp;
                er1 = (owner[k] == 1) && sp;
            end
            check("ready0", k, 64'(r0[k]), 64'(er0));
            check("ready1", k, 64'(r1[k]), 64'(er1));
            check("out_valid", k, 64'(ov[k]), 64'(mcnt[k] > 0));
            if (mcnt[k] > 0) begin
                check("out_data", k, 64'(od[k]), 64'(mq[k][0][31:0]));
                check("out_sel", k, 64'(os[k]), 64'(mq[k][0][32]));
            end
            pop = (mcnt[k] > 0) && ordy;
            a0  = v0 && er0;
            a1  = v1 && er1;
            if (pop) begin
                mq[k][0] = mq[k][1];
                mcnt[k]--;
            end
            if (a0 || a1) begin
                mq[k][mcnt[k]] = a1 ? {1'b1, d1} : {1'b0, d0};
                mcnt[k]++;
                if (owner[k] < 0) begin
                    last[k] = a1 ? 1 : 0;
                    if (beats[k] > 1) begin
                        owner[k] = last[k];
                        left[k]  = beats[k] - 1;
                    end
                end else begin
                    left[k]--;
                    if (left[k] == 0) owner[k] = -1;
                end
            end
            acc0[k] = a0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] seq [3];
        int idx;
        int gap;
        seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33;
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; ordy = 1'b1; d0 = '0; d1 = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Both requesters always valid: round robin, 1-beat instance alternates 0,1,0,1.
        do_reset();
        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d0 = 32'hA000_0000 + 32'(i);
            d1 = 32'hB000_0000 + 32'(i);
            if (i >= 1) begin
                #1;
                check("alt_valid", 0, 64'(ov[0]), 64'd1);
                check("alt_sel", 0, 64'(os[0]), 64'((i - 1) % 2));
            end
            step();
        end

        // Four-beat lock with a 3-cycle gap from requester 0 after its second beat.
        do_reset();
        v0 = 1'b1; v1 = 1'b0; ordy = 1'b1; idx = 0; gap = 0;
        for (int i = 0; i < 16; i++) begin
            d0 = 32'hC000_0000 + 32'(i);
            d1 = 32'hD000_0000 + 32'(i);
            if (i >= 1) v1 = 1'b1;
            v0 = !(idx == 2 && gap < 3);
            if (idx == 2 && gap < 3) begin
                #1;
                check("gap_rdy1", 1, 64'(r1[1]), 64'd0);
                gap++;
            end
            step();
            if (acc0[1]) idx++;
        end

        // Output stalled for 5 cycles while requester 0 streams 0x11,0x22,0x33.
        do_reset();
        v1 = 1'b0; ordy = 1'b0; idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) ordy = 1'b1;
            v0 = (idx < 3);
            d0 = (idx < 3) ? seq[idx] : 32'h0;
            if (i == 4) begin
                #1;
                check("full_rdy0", 0, 64'(r0[0]), 64'd0);
                check("full_head", 0, 64'(od[0]), 64'h11);
            end
            step();
            if (acc0[0]) idx++;
        end

        // Randomized traffic and backpressure.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v0   = ($urandom_range(3) != 0);
            v1   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(2) != 0);
            d0   = $urandom;
            d1   = $urandom;
            step();
        end

        // Reset in the middle of a 4-beat burst with one beat buffered.
        do_reset();
        v0 = 1'b1; v1 = 1'b0; ordy = 1'b0; d0 = 32'hE0;
        step();
        v0 = 1'b0;
        #1;
        check("pre_rst_valid", 1, 64'(ov[1]), 64'd1);
        do_reset();
        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d0 = 32'hF000_0000 + 32'(i);
            d1 = 32'hF100_0000 + 32'(i);
            if (i >= 1 && i <= 8) begin
                #1;
                check("post_rst_sel", 1, 64'(os[1]), 64'(i >= 5));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
